// File: rtl/data_stack_system_pkg.sv
// Shared widths and control encodings for the data-stack datapath.
// Imported by the top level and the register-file sub-module.
package data_stack_system_pkg;

    localparam int DEFAULT_WIDTH      = 16;
    localparam int DEFAULT_DEPTH_LOG2 = 4;

    // TR source select codes; 5..7 mean "hold TR".
    localparam logic [2:0] SRC_A   = 3'd0;
    localparam logic [2:0] SRC_B   = 3'd1;
    localparam logic [2:0] SRC_C   = 3'd2;
    localparam logic [2:0] SRC_D   = 3'd3;
    localparam logic [2:0] SRC_POP = 3'd4;

    // DP control codes; 3 also holds.
    localparam logic [1:0] DP_HOLD = 2'd0;
    localparam logic [1:0] DP_INC  = 2'd1;
    localparam logic [1:0] DP_DEC  = 2'd2;

endpackage

// File: rtl/data_stack_system_stack_reg_file.sv
// Backing store for the data stack: synchronous write, asynchronous read,
// and asynchronous clear of every entry.
module stack_reg_file
    import data_stack_system_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_en,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WIDTH-1:0]      write_data,
    output logic [WIDTH-1:0]      read_data
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array is built from resettable flops rather than a RAM macro
    // because every entry must read back as zero the moment reset asserts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (write_en) begin
            mem[addr] <= write_data;
        end
    end

    assign read_data = mem[addr];

endmodule

// File: rtl/data_stack_system.sv
// Data-stack datapath: top-of-stack register TR, its source mux, the data
// pointer DP, and the register file holding the rest of the stack.
module data_stack_system
    import data_stack_system_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [WIDTH-1:0] tr_src_a,
    input  logic [WIDTH-1:0] tr_src_b,
    input  logic [WIDTH-1:0] tr_src_c,
    input  logic [WIDTH-1:0] tr_src_d,
    input  logic [2:0]       tr_src,
    input  logic             tr_write,
    input  logic [1:0]       dp_inc,
    input  logic             reg_write,
    output logic [WIDTH-1:0] TR,
    output logic [WIDTH-1:0] read_data
);

    logic [DEPTH_LOG2-1:0] dp;
    logic [DEPTH_LOG2-1:0] dp_next;
    logic [WIDTH-1:0]      tr_next;

    // NOTE: every always_comb output gets a default first so no code path
    // leaves it unassigned and infers a latch.
    always_comb begin
        tr_next = TR;
        case (tr_src)
            SRC_A:   tr_next = tr_src_a;
            SRC_B:   tr_next = tr_src_b;
            SRC_C:   tr_next = tr_src_c;
            SRC_D:   tr_next = tr_src_d;
            SRC_POP: tr_next = read_data;
            default: tr_next = TR;
        endcase
    end

    // DP wraps naturally at its bit width; the stack has no over/underflow flags.
    always_comb begin
        dp_next = dp;
        case (dp_inc)
            DP_HOLD: dp_next = dp;
            DP_INC:  dp_next = dp + 1'b1;
            DP_DEC:  dp_next = dp - 1'b1;
            default: dp_next = dp;
        endcase
    end

    // NOTE: non-blocking assignments make the register file, TR and DP all
    // sample pre-edge values, which is what makes a one-edge push/pop work.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            TR <= '0;
            dp <= '0;
        end else begin
            if (tr_write) begin
                TR <= tr_next;
            end
            dp <= dp_next;
        end
    end

    stack_reg_file #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_stack_reg_file (
        .clk        (CLK),
        .rst        (reset),
        .write_en   (reg_write),
        .addr       (dp),
        .write_data (TR),
        .read_data  (read_data)
    );

endmodule

// File: tb/tb_data_stack_system.sv
// Directed self-checking bench for data_stack_system: push, pop, DP wrap,
// simultaneous controls and asynchronous reset.
module tb_data_stack_system;
    import data_stack_system_pkg::*;

    logic        CLK = 1'b0;
    logic        reset;
    logic [15:0] tr_src_a, tr_src_b, tr_src_c, tr_src_d;
    logic [2:0]  tr_src;
    logic        tr_write;
    logic [1:0]  dp_inc;
    logic        reg_write;
    logic [15:0] TR;
    logic [15:0] read_data;

    int tests_run = 0;
    int tests_failed = 0;

    data_stack_system dut (
        .CLK       (CLK),
        .reset     (reset),
        .tr_src_a  (tr_src_a),
        .tr_src_b  (tr_src_b),
        .tr_src_c  (tr_src_c),
        .tr_src_d  (tr_src_d),
        .tr_src    (tr_src),
        .tr_write  (tr_write),
        .dp_inc    (dp_inc),
        .reg_write (reg_write),
        .TR        (TR),
        .read_data (read_data)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, observed, expected);
        end
    endtask

    // Apply controls, take one rising edge, return #1 after it with controls idle.
    task automatic cycle(input logic [2:0] src, input logic tw, input logic rw, input logic [1:0] inc);
        tr_src    = src;
        tr_write  = tw;
        reg_write = rw;
        dp_inc    = inc;
        @(posedge CLK);
        #1;
        tr_write  = 1'b0;
        reg_write = 1'b0;
        dp_inc    = DP_HOLD;
        tr_src    = SRC_A;
    endtask

    initial begin
        reset     = 1'b1;
        tr_src_a  = 16'd1;
        tr_src_b  = 16'd2;
        tr_src_c  = 16'd3;
        tr_src_d  = 16'd4;
        tr_src    = SRC_A;
        tr_write  = 1'b0;
        dp_inc    = DP_HOLD;
        reg_write = 1'b0;

        repeat (2) @(posedge CLK);
        #1;
        check("reset_tr", TR, 16'h0000);
        check("reset_rd", read_data, 16'h0000);
        check("reset_dp", 16'(dut.dp), 16'd0);
        @(negedge CLK);
        reset = 1'b0;
        @(posedge CLK);
        #1;

        cycle(SRC_D, 1'b1, 1'b0, DP_HOLD);
        check("load_d_tr", TR, 16'd4);

        cycle(SRC_B, 1'b1, 1'b1, DP_HOLD);
        check("push0_tr", TR, 16'd2);
        check("push0_rd", read_data, 16'd4);

        cycle(SRC_A, 1'b0, 1'b0, DP_INC);
        check("inc_dp", 16'(dut.dp), 16'd1);
        check("inc_rd", read_data, 16'd0);

        cycle(SRC_A, 1'b0, 1'b0, DP_HOLD);
        check("idle_tr", TR, 16'd2);

        cycle(SRC_C, 1'b1, 1'b1, DP_HOLD);
        check("push1_tr", TR, 16'd3);
        check("push1_rd", read_data, 16'd2);

        cycle(SRC_A, 1'b0, 1'b0, DP_DEC);
        check("dec_rd", read_data, 16'd4);

        cycle(SRC_POP, 1'b1, 1'b0, DP_HOLD);
        check("pop_tr", TR, 16'd4);

        cycle(SRC_A, 1'b0, 1'b0, DP_DEC);
        check("wrap_dn_dp", 16'(dut.dp), 16'd15);
        check("wrap_dn_rd", read_data, 16'd0);

        cycle(SRC_A, 1'b0, 1'b0, DP_INC);
        check("wrap_up_dp", 16'(dut.dp), 16'd0);
        check("wrap_up_rd", read_data, 16'd4);

        cycle(3'd5, 1'b1, 1'b0, DP_HOLD);
        check("hold5_tr", TR, 16'd4);
        cycle(3'd6, 1'b1, 1'b0, DP_HOLD);
        check("hold6_tr", TR, 16'd4);
        cycle(3'd7, 1'b1, 1'b0, 2'd3);
        check("hold7_tr", TR, 16'd4);
        check("dp3_hold", 16'(dut.dp), 16'd0);

        // Push with increment: write lands at old DP (0), DP moves to 1.
        tr_src_a = 16'h1234;
        tr_src_b = 16'hBEEF;
        cycle(SRC_A, 1'b1, 1'b0, DP_HOLD);
        check("load_a_tr", TR, 16'h1234);
        cycle(SRC_B, 1'b1, 1'b1, DP_INC);
        check("pushinc_tr", TR, 16'hBEEF);
        check("pushinc_dp", 16'(dut.dp), 16'd1);
        check("pushinc_rd", read_data, 16'd2);

        // Pop with decrement: TR takes mem[1], then DP drops to 0.
        cycle(SRC_POP, 1'b1, 1'b0, DP_DEC);
        check("popdec_tr", TR, 16'd2);
        check("popdec_dp", 16'(dut.dp), 16'd0);
        check("popdec_rd", read_data, 16'h1234);

        cycle(SRC_A, 1'b0, 1'b0, DP_INC);
        check("pre_rst_dp", 16'(dut.dp), 16'd1);

        // Asynchronous reset between edges.
        #2;
        reset = 1'b1;
        #1;
        check("arst_tr", TR, 16'h0000);
        check("arst_rd", read_data, 16'h0000);
        check("arst_dp", 16'(dut.dp), 16'd0);

        cycle(SRC_A, 1'b1, 1'b1, DP_INC);
        check("rst_blk_tr", TR, 16'h0000);
        check("rst_blk_dp", 16'(dut.dp), 16'd0);
        check("rst_blk_rd", read_data, 16'h0000);

        @(negedge CLK);
        reset = 1'b0;
        @(posedge CLK);
        #1;
        check("clr_mem0", read_data, 16'h0000);
        cycle(SRC_A, 1'b0, 1'b0, DP_INC);
        check("clr_mem1", read_data, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
